conv_out_reader: RTL and testbench
==================================

// Module: conv_out_reader
// PURPOSE
//  Drains the pointwise-conv output SRAM after a layer completes and streams it to the host/DMA.
//  Output is int8 conv_11 results, 16 ch x 112 rows x 112 cols, packed 4 pixels per 32-bit word.
//  The block generates SRAM read addresses in ch->row->word order and absorbs the 1-cycle SRAM
//  read latency with a small credit-managed FIFO. It drives a valid/ready master stream with
//  row/frame end markers. It is the read-side counterpart of the accelerator's output-SRAM writer.
// PARAMETERS
//  DATA_W      32   SRAM word / stream width (4 x int8)
//  ADDR_W      16   SRAM address width
//  N_CH        16   output channels
//  N_ROW       112  rows per channel
//  N_WORD      28   words per row (112/4)
//  FIFO_DEPTH  4    output FIFO entries (power of 2, >=2)
// PORTS
//  clk           in   1       clock, rising edge
//  rst_n         in   1       async active-low reset
//  start         in   1       1-cycle pulse; begins a frame drain when IDLE
//  clr           in   1       sync abort; returns to IDLE, flushes FIFO
//  busy          out  1       high from accepted start until done
//  done          out  1       1-cycle pulse after last word handshaken
//  sram_rd_en    out  1       SRAM read strobe
//  sram_addr     out  ADDR_W  ch*N_ROW*N_WORD + row*N_WORD + word
//  sram_rdata    in   DATA_W  valid exactly 1 cycle after sram_rd_en
//  m_valid       out  1       stream data valid
//  m_ready       in   1       stream sink ready
//  m_data        out  DATA_W  [31:24]=pixel 4w+0 ... [7:0]=pixel 4w+3
//  m_last_row    out  1       word is last of a row (word==N_WORD-1)
//  m_last_frame  out  1       word is last of frame (ch,row,word all max)
//  checksum      out  32      only with CONV_OUT_CHKSUM_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset: busy=0, done=0, sram_rd_en=0, sram_addr=0, m_valid=0, m_data=0, flags=0,
//   counters=0, FIFO empty, state=IDLE.
//  FSM: IDLE -start-> RUN. RUN -last address issued-> DRAIN. DRAIN -last word handshaken->
//   DONE. DONE -> IDLE after 1 cycle, with done=1 in DONE. clr in any state -> IDLE next
//   cycle. clr has priority over start.
//  start is ignored unless in IDLE. busy=1 in RUN/DRAIN/DONE.
//  Read issue: in RUN, sram_rd_en=1 iff (fifo_count + inflight) < FIFO_DEPTH. inflight is 0 or 1.
//   Address counters (word, row, ch) advance on each issue. word wraps at N_WORD and carries
//   into row. row wraps at N_ROW and carries into ch.
//  Capture: a registered copy of sram_rd_en, one cycle later, pushes sram_rdata plus
//   precomputed last_row/last_frame tags into the FIFO. Credit rule guarantees no overflow.
//  Stream: m_valid = FIFO non-empty. Pop on m_valid&&m_ready. m_data/flags are stable while
//   m_valid && !m_ready. Push and pop in the same cycle leave the count unchanged.
//  Throughput: 1 word/cycle sustained with m_ready=1. First m_valid 2 cycles after start.
//   Total N_CH*N_ROW*N_WORD = 50176 words.
//  Backpressure: m_ready=0 stalls issue once credits are exhausted. No data loss or duplication.
//  clr mid-frame: pending read data is discarded (capture suppressed), FIFO pointers reset,
//   m_valid=0 next cycle, done is not pulsed.
//  Reset mid-operation: immediate return to reset values; no output beyond the reset state.
// CONFIGURATION
//  CONV_OUT_CHKSUM_EN defined: checksum = 32-bit wrapping sum of all streamed bytes, each
//   sign-extended int8, accumulated on each handshake. Cleared to 0 on accepted start, clr
//   and reset. Holds its final value after done.
//  Not defined: checksum port and accumulator are absent. All other behaviour is identical.
// TESTING
//  1 SRAM word[a]=a, m_ready=1, start -> 50176 words in order, m_data==addr; m_last_row on every
//    28th word; m_last_frame only on word 50175; done 1 cycle after it; busy drops next cycle.
//  2 Random m_ready (50%) -> identical sequence to test 1; m_data held while stalled; sram_rd_en
//    never issued when count+inflight==4.
//  3 clr at word 1000 with m_ready=0 -> m_valid=0 next cycle, no done, state IDLE; fresh start
//    restarts at addr 0.
//  4 rst_n low at word 500 -> all outputs 0 asynchronously; start after release -> addr 0.
//  5 start pulsed while busy -> ignored; word count stays 50176, single done.
//  6 CONV_OUT_CHKSUM_EN, all bytes 8'hFF (-1) -> checksum 32'hFFFC_F000 (-200704) at done.

Source files
------------

// File: rtl/conv_out_reader.sv
// conv_out_reader: drains the conv output SRAM in ch->row->word order into a
// valid/ready stream with row/frame end tags. Optional macro CONV_OUT_CHKSUM_EN.
//
// Ports: clk, rst_n (async low); start/clr control; busy/done status;
// sram_rd_en/sram_addr/sram_rdata (1-cycle read latency);
// m_valid/m_ready/m_data/m_last_row/m_last_frame stream;
// checksum (only with CONV_OUT_CHKSUM_EN).
module conv_out_reader #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int N_CH       = 16,
  parameter int N_ROW      = 112,
  parameter int N_WORD     = 28,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clr,
  output logic              busy,
  output logic              done,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last_row,
  output logic              m_last_frame
`ifdef CONV_OUT_CHKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int WW = (N_WORD > 1) ? $clog2(N_WORD) : 1;
  localparam int RW = (N_ROW > 1) ? $clog2(N_ROW) : 1;
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [WW-1:0]     word_q, word_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rdv_q, tag_lr_q, tag_lf_q;
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [PW:0]       cnt_q, cnt_d;
  logic [DATA_W+1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W+1:0] head;

  logic start_ok, issue, push, pop;
  logic is_lw, is_lr, is_lc, is_lf;

  assign start_ok = start && !clr && (state_q == S_IDLE);
  assign is_lw    = (word_q == WW'(N_WORD - 1));
  assign is_lr    = (row_q == RW'(N_ROW - 1));
  assign is_lc    = (ch_q == CW'(N_CH - 1));
  assign is_lf    = is_lw && is_lr && is_lc;

  // Credits: FIFO occupancy plus the read still in the SRAM pipe.
  assign issue = (state_q == S_RUN) && !clr &&
                 (({1'b0, cnt_q} + (PW+2)'(rdv_q)) < (PW+2)'(FIFO_DEPTH));

  assign push = rdv_q && !clr;
  assign head = mem_q[rptr_q];

  assign m_valid      = (cnt_q != '0);
  assign m_data       = m_valid ? head[DATA_W+1:2] : '0;
  assign m_last_row   = m_valid && head[1];
  assign m_last_frame = m_valid && head[0];
  assign pop          = m_valid && m_ready;

  assign sram_rd_en = issue;
  assign sram_addr  = addr_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_ok) state_d = S_RUN;
      S_RUN:   if (issue && is_lf) state_d = S_DRAIN;
      S_DRAIN: if (pop && m_last_frame) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clr) state_d = S_IDLE;
  end

  always_comb begin
    word_d = word_q;
    row_d  = row_q;
    ch_d   = ch_q;
    addr_d = addr_q;
    if (clr || start_ok) begin
      word_d = '0;
      row_d  = '0;
      ch_d   = '0;
      addr_d = '0;
    end else if (issue) begin
      addr_d = addr_q + ADDR_W'(1);
      if (is_lw) begin
        word_d = '0;
        if (is_lr) begin
          row_d = '0;
          ch_d  = is_lc ? '0 : ch_q + CW'(1);
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        word_d = word_q + WW'(1);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    if (clr) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      word_q   <= '0;
      row_q    <= '0;
      ch_q     <= '0;
      addr_q   <= '0;
      rdv_q    <= 1'b0;
      tag_lr_q <= 1'b0;
      tag_lf_q <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      row_q   <= row_d;
      ch_q    <= ch_d;
      addr_q  <= addr_d;
      rdv_q   <= issue;
      if (issue) begin
        tag_lr_q <= is_lw;
        tag_lf_q <= is_lf;
      end
      cnt_q <= cnt_d;
      if (clr) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + PW'(1);
        if (pop)  rptr_q <= rptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q] <= {sram_rdata, tag_lr_q, tag_lf_q};
    end
  end

`ifdef CONV_OUT_CHKSUM_EN
  logic [31:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (clr || start_ok) begin
      csum_d = '0;
    end else if (pop) begin
      for (int i = 0; i < DATA_W / 8; i++)
        csum_d = csum_d + {{24{m_data[8*i+7]}}, m_data[8*i +: 8]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_conv_out_reader.sv
// tb_conv_out_reader: table-driven frames with random m_ready against a
// linear-order reference, plus clr, reset and double-start sequences.
module tb_conv_out_reader;

  localparam int NC    = 3;
  localparam int NR    = 4;
  localparam int NW    = 5;
  localparam int TOT   = NC * NR * NW;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clr = 1'b0;
  logic        m_ready = 1'b0;
  logic        busy, done, sram_rd_en;
  logic [15:0] sram_addr;
  logic [31:0] sram_rdata = '0;
  logic [31:0] m_data;
  logic        m_valid, m_last_row, m_last_frame;
`ifdef CONV_OUT_CHKSUM_EN
  logic [31:0] checksum;
`endif

  conv_out_reader #(
    .DATA_W(32), .ADDR_W(16), .N_CH(NC), .N_ROW(NR),
    .N_WORD(NW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
    .busy(busy), .done(done),
    .sram_rd_en(sram_rd_en), .sram_addr(sram_addr),
    .sram_rdata(sram_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last_row(m_last_row), .m_last_frame(m_last_frame)
`ifdef CONV_OUT_CHKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] salt = '0;
  bit all_ff = 1'b0;

  function automatic logic [31:0] f(input int a);
    return all_ff ? 32'hFFFF_FFFF : (32'(a) ^ salt);
  endfunction

  always @(posedge clk)
    sram_rdata <= sram_rd_en ? f(int'(sram_addr)) : $urandom();

  int cyc = 0;
  int exp_idx, issued, popped, done_cnt, last_hs, first_v, start_cyc;
  int rdy_pct = 100;
  bit held_v, prev_done, held_lr, held_lf;
  logic [31:0] held_d, csum_m;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic mon_reset();
    exp_idx = 0; issued = 0; popped = 0; done_cnt = 0;
    last_hs = -100; first_v = -1; held_v = 0; prev_done = 0;
    csum_m = '0;
  endtask

  task automatic monitor();
    cyc++;
    if (sram_rd_en) begin
      chk("rd_addr", 64'(sram_addr), 64'(issued));
      chk("credit", 64'(issued - popped < DEPTH), 64'd1);
      issued++;
    end
    if (held_v) begin
      chk("hold_valid", 64'(m_valid), 64'd1);
      chk("hold_data", 64'(m_data), 64'(held_d));
      chk("hold_flags", 64'({m_last_row, m_last_frame}),
          64'({held_lr, held_lf}));
    end
    held_v = 0;
    if (m_valid && first_v < 0) first_v = cyc;
    if (m_valid && m_ready) begin
      chk("data", 64'(m_data), 64'(f(exp_idx)));
      chk("last_row", 64'(m_last_row), 64'(exp_idx % NW == NW - 1));
      chk("last_frame", 64'(m_last_frame), 64'(exp_idx == TOT - 1));
      for (int i = 0; i < 4; i++)
        csum_m = csum_m + 32'(int'($signed(m_data[8*i +: 8])));
      exp_idx++; popped++; last_hs = cyc;
    end else if (m_valid) begin
      held_v = 1; held_d = m_data;
      held_lr = m_last_row; held_lf = m_last_frame;
    end
    if (prev_done) chk("busy_after_done", 64'(busy), 64'd0);
    if (done) begin
      done_cnt++;
      chk("done_delay", 64'(cyc - last_hs), 64'd1);
      chk("done_words", 64'(exp_idx), 64'(TOT));
`ifdef CONV_OUT_CHKSUM_EN
      chk("checksum", 64'(checksum), 64'(csum_m));
`endif
    end
    prev_done = done;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    m_ready = ($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic run_frame(input int extra_at, output int words,
                           output int dones);
    int post;
    bit timed_out;
    mon_reset();
    start = 1'b1;
    tick();
    start_cyc = cyc;
    start = 1'b0;
    post = -1;
    timed_out = 1;
    for (int k = 0; k < 30 * TOT + 100; k++) begin
      if (k == extra_at) start = 1'b1;
      tick();
      start = 1'b0;
      if (done_cnt > 0 && post < 0) post = 0;
      if (post >= 0) post++;
      if (post > 5) begin
        timed_out = 0;
        break;
      end
    end
    if (timed_out) chk("frame_timeout", 64'd1, 64'd0);
    words = exp_idx;
    dones = done_cnt;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_done"}, 64'(done), 64'd0);
    chk({nm, "_rd_en"}, 64'(sram_rd_en), 64'd0);
    chk({nm, "_addr"}, 64'(sram_addr), 64'd0);
    chk({nm, "_valid"}, 64'(m_valid), 64'd0);
    chk({nm, "_data"}, 64'(m_data), 64'd0);
    chk({nm, "_flags"}, 64'({m_last_row, m_last_frame}), 64'd0);
  endtask

  typedef struct {
    int          pct;
    int          extra_at;
    logic [31:0] salt;
    int          exp_words;
    int          exp_dones;
  } vec_t;

  vec_t tv[5];

  initial begin
    int w, d, lim;
    tv[0] = '{100, -1, 32'h0000_0000, TOT, 1};
    tv[1] = '{50, -1, 32'hA5C3_0000, TOT, 1};
    tv[2] = '{30, 7, 32'h1234_5678, TOT, 1};
    tv[3] = '{100, 25, 32'hFF00_FF00, TOT, 1};
    tv[4] = '{75, 40, 32'h0F0F_0000, TOT, 1};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int t = 0; t < 5; t++) begin
      rdy_pct = tv[t].pct;
      salt = tv[t].salt;
      run_frame(tv[t].extra_at, w, d);
      chk("words", 64'(w), 64'(tv[t].exp_words));
      chk("dones", 64'(d), 64'(tv[t].exp_dones));
      chk("first_valid", 64'(first_v - start_cyc), 64'd3);
      if (tv[t].pct == 100)
        chk("throughput", 64'(last_hs - start_cyc), 64'(TOT + 2));
    end

    // clr mid-frame while the sink is stalled
    rdy_pct = 100;
    salt = 32'h5A5A_0000;
    mon_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    lim = 0;
    while (exp_idx < 20 && lim < 200) begin
      tick();
      lim++;
    end
    chk("clr_reach", 64'(exp_idx >= 20), 64'd1);
    rdy_pct = 0;
    m_ready = 1'b0;
    repeat (4) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    held_v = 0;
    repeat (8) begin
      @(negedge clk);
      chk("clr_valid", 64'(m_valid), 64'd0);
      chk("clr_busy", 64'(busy), 64'd0);
      chk("clr_done", 64'(done), 64'd0);
      chk("clr_rd_en", 64'(sram_rd_en), 64'd0);
      @(posedge clk);
      #1;
    end
    rdy_pct = 100;
    run_frame(-1, w, d);
    chk("clr_restart_words", 64'(w), 64'(TOT));
    chk("clr_restart_dones", 64'(d), 64'd1);

    // asynchronous reset mid-frame
    rdy_pct = 70;
    salt = 32'h0BAD_0000;
    mon_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    lim = 0;
    while (exp_idx < 15 && lim < 300) begin
      tick();
      lim++;
    end
    chk("rst_reach", 64'(exp_idx >= 15), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("async_rst");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(-1, w, d);
    chk("rst_restart_words", 64'(w), 64'(TOT));
    chk("rst_restart_dones", 64'(d), 64'd1);

`ifdef CONV_OUT_CHKSUM_EN
    all_ff = 1'b1;
    rdy_pct = 60;
    run_frame(-1, w, d);
    chk("chksum_allff", 64'(checksum), 64'(32'(-4 * TOT)));
    repeat (3) tick();
    chk("chksum_hold", 64'(checksum), 64'(32'(-4 * TOT)));
    all_ff = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
